// File: rtl/sram_readback_pkg.sv
// Shared types and defaults for the SRAM readback sequencer.
package sram_readback_pkg;

  localparam int unsigned RB_CNT_W      = 20;
  // Matches the sram_interface read pipeline depth.
  localparam int unsigned RB_RD_LATENCY = 4;
  localparam int unsigned RB_DATA_W     = 32;
  localparam int unsigned RB_LANES      = 4;

  typedef enum logic [2:0] {
    RB_IDLE   = 3'd0,
    RB_ISSUE  = 3'd1,
    RB_WAIT   = 3'd2,
    RB_SEND   = 3'd3,
    RB_TXWAIT = 3'd4,
    RB_FIN    = 3'd5
  } rb_state_e;

  // One sample as handed to the transmitter.
  typedef struct packed {
    logic [RB_DATA_W-1:0] data;
    logic [RB_LANES-1:0]  mask;
  } rb_sample_t;

endpackage

// File: rtl/sram_readback.sv
// Read-side sequencer: strobes the SRAM once per sample, waits out the read
// latency, latches the returned word and hands it to the UART transmitter.
module sram_readback
  import sram_readback_pkg::*;
#(
  parameter int unsigned CNT_W      = RB_CNT_W,
  parameter int unsigned RD_LATENCY = RB_RD_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     read_count,
  input  logic                 abort,
  output logic                 rd_strobe,
  input  logic [RB_DATA_W-1:0] sram_rddata,
  input  logic [RB_LANES-1:0]  sram_rdvalid,
  output logic [RB_DATA_W-1:0] tx_data,
  output logic [RB_LANES-1:0]  tx_mask,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  rb_state_e        state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             abort_pend_q, abort_pend_d;
  rb_sample_t       sample_q, sample_d;
  logic             rd_strobe_q, rd_strobe_d;
  logic             tx_send_q, tx_send_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RB_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort in TXWAIT lets the in-flight transfer finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RB_IDLE:   if (start) state_d = (read_count != '0) ? RB_ISSUE : RB_FIN;
      RB_ISSUE:  state_d = abort ? RB_FIN : RB_WAIT;
      RB_WAIT: begin
        if (abort)                  state_d = RB_FIN;
        else if (lat_cnt_q == '0)   state_d = RB_SEND;
      end
      RB_SEND: begin
        if (abort)        state_d = RB_FIN;
        else if (tx_busy) state_d = RB_TXWAIT;
      end
      RB_TXWAIT: begin
        if (!tx_busy)
          state_d = (remaining_q == '0 || abort || abort_pend_q) ? RB_FIN : RB_ISSUE;
      end
      RB_FIN:    state_d = RB_IDLE;
      default:   state_d = RB_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with it.
  always_comb begin
    rd_strobe_d = (state_d == RB_ISSUE);
    tx_send_d   = (state_d == RB_SEND);
    busy_d      = (state_d != RB_IDLE);
    done_d      = (state_d == RB_FIN);
  end

  // Datapath next values: sample counter, latency counter, abort memory, sample latch.
  always_comb begin
    remaining_d  = remaining_q;
    lat_cnt_d    = lat_cnt_q;
    abort_pend_d = abort_pend_q;
    sample_d     = sample_q;
    case (state_q)
      RB_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) remaining_d = read_count;
      end
      RB_ISSUE:  lat_cnt_d = LAT_W'(RD_LATENCY - 1);
      RB_WAIT: begin
        if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - LAT_W'(1);
        else if (!abort)     sample_d  = '{data: sram_rddata, mask: sram_rdvalid};
      end
      RB_SEND: begin
        if (!abort && tx_busy && remaining_q != '0)
          remaining_d = remaining_q - CNT_W'(1);
      end
      RB_TXWAIT: if (abort) abort_pend_d = 1'b1;
      RB_FIN:    abort_pend_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_q  <= '0;
      lat_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      sample_q     <= '0;
      rd_strobe_q  <= 1'b0;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      remaining_q  <= remaining_d;
      lat_cnt_q    <= lat_cnt_d;
      abort_pend_q <= abort_pend_d;
      sample_q     <= sample_d;
      rd_strobe_q  <= rd_strobe_d;
      tx_send_q    <= tx_send_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_strobe = rd_strobe_q;
  assign tx_send   = tx_send_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tx_data   = sample_q.data;
  assign tx_mask   = sample_q.mask;

endmodule

// File: tb/tb_sram_readback.sv
// Directed bench for sram_readback with an SRAM latency model and a UART busy responder.
module tb_sram_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] read_count;
  logic        abort;
  logic        rd_strobe;
  logic [31:0] sram_rddata;
  logic [3:0]  sram_rdvalid;
  logic [31:0] tx_data;
  logic [3:0]  tx_mask;
  logic        tx_send;
  logic        tx_busy;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sram_readback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .read_count(read_count), .abort(abort),
    .rd_strobe(rd_strobe), .sram_rddata(sram_rddata), .sram_rdvalid(sram_rdvalid),
    .tx_data(tx_data), .tx_mask(tx_mask), .tx_send(tx_send), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );

  // SRAM model: word valid in the 4th cycle after the strobe cycle, junk otherwise.
  logic [31:0] model_data = 32'h0;
  logic [3:0]  model_mask = 4'h0;
  logic [3:0]  rd_pipe = 4'h0;
  always @(posedge clk) rd_pipe <= {rd_pipe[2:0], rd_strobe};
  assign sram_rddata  = rd_pipe[3] ? model_data : 32'h0BAD_0BAD;
  assign sram_rdvalid = rd_pipe[3] ? model_mask : 4'h0;

  // Transmitter: automatic responder or manual control.
  logic tx_auto = 1'b1;
  int   busy_hold = 1;
  logic tx_busy_auto;
  logic tx_busy_man = 1'b0;
  int   busy_cnt;
  assign tx_busy = tx_auto ? tx_busy_auto : tx_busy_man;

  initial begin
    tx_busy_auto = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy_auto = 1'b0;
      end else if (tx_auto && tx_send && !tx_busy_auto) begin
        tx_busy_auto = 1'b1;
        busy_cnt = busy_hold;
      end
    end
  end

  // Event monitor: counts only; the test tasks compare these counts.
  int n_strobe = 0, n_send = 0, n_done = 0, n_gap_viol = 0;
  int n_send_busy = 0, n_strobe_busy = 0, n_data_chg = 0;
  initial begin
    int cyc, last_strobe;
    logic prev_send;
    logic [31:0] prev_data;
    logic [3:0] prev_mask;
    cyc = 0; last_strobe = -100; prev_send = 1'b0; prev_data = '0; prev_mask = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rd_strobe === 1'b1) begin
        n_strobe++;
        if (cyc - last_strobe < 7) n_gap_viol++;
        last_strobe = cyc;
      end
      if (tx_send === 1'b1 && !prev_send) n_send++;
      if (done === 1'b1) n_done++;
      if (tx_send === 1'b1 && tx_busy === 1'b1) n_send_busy++;
      if (rd_strobe === 1'b1 && tx_busy === 1'b1) n_strobe_busy++;
      if (prev_send && tx_send === 1'b1 && (tx_data !== prev_data || tx_mask !== prev_mask))
        n_data_chg++;
      prev_send = (tx_send === 1'b1);
      prev_data = tx_data;
      prev_mask = tx_mask;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after start was sampled.
  task automatic pulse_start(input logic [19:0] n);
    @(negedge clk);
    start = 1'b1;
    read_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        cycles = i + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0; start = 1'b1; read_count = 20'd5; abort = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd_strobe, tx_send, busy, done} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 0000", {rd_strobe, tx_send, busy, done});
    end
    tests_run++;
    if ({tx_data, tx_mask} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h, required 0/0", tx_data, tx_mask);
    end
    start = 1'b0;
    rst_n = 1'b1;
    idle(2);
    d0 = n_done;
    abort = 1'b1;
    idle(3);
    abort = 1'b0;
    idle(1);
    tests_run++;
    if (busy !== 1'b0 || n_done != d0) begin
      tests_failed++;
      $display("FAIL idle_abort: got busy=%b dones=%0d, required busy=0 dones=0", busy, n_done - d0);
    end
  endtask

  task automatic test_basic();
    int s0, t0, d0, cycles;
    bit seen;
    model_data = 32'h1234_5678; model_mask = 4'hF; tx_auto = 1'b1; busy_hold = 1;
    s0 = n_strobe; t0 = n_send; d0 = n_done;
    pulse_start(20'd3);
    tests_run++;
    if (rd_strobe !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_first_strobe: got strobe=%b busy=%b, required 1 1", rd_strobe, busy);
    end
    wait_done(100, cycles, seen);
    tests_run++;
    if (!seen || cycles != 21) begin
      tests_failed++;
      $display("FAIL basic_done_time: got seen=%0d cycles=%0d, required seen=1 cycles=21", seen, cycles);
    end
    idle(3);
    tests_run++;
    if (n_strobe - s0 != 3 || n_send - t0 != 3 || n_done - d0 != 1) begin
      tests_failed++;
      $display("FAIL basic_counts: got strobes=%0d sends=%0d dones=%0d, required 3 3 1",
               n_strobe - s0, n_send - t0, n_done - d0);
    end
    tests_run++;
    if (busy !== 1'b0 || tx_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL basic_end: got busy=%b data=%h, required busy=0 data=12345678", busy, tx_data);
    end
  endtask

  task automatic test_zero_count();
    int s0, t0;
    s0 = n_strobe; t0 = n_send;
    pulse_start(20'd0);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_fin: got done=%b busy=%b strobe=%b, required 1 1 0", done, busy, rd_strobe);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_idle: got done=%b busy=%b, required 0 0", done, busy);
    end
    idle(10);
    tests_run++;
    if (n_strobe != s0 || n_send != t0) begin
      tests_failed++;
      $display("FAIL zero_no_traffic: got strobes=%0d sends=%0d, required 0 0", n_strobe - s0, n_send - t0);
    end
  endtask

  task automatic test_latency();
    bit early, unstable;
    tx_auto = 1'b0; tx_busy_man = 1'b0;
    model_data = 32'hDEAD_BEEF; model_mask = 4'h7;
    early = 1'b0; unstable = 1'b0;
    pulse_start(20'd1);
    repeat (4) begin
      @(negedge clk);
      if (tx_send !== 1'b0 || tx_data === 32'hDEAD_BEEF) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL lat_early: got send/data before latency, required send=0 data=12345678");
    end
    @(negedge clk);
    tests_run++;
    if (tx_send !== 1'b1 || tx_data !== 32'hDEAD_BEEF || tx_mask !== 4'h7) begin
      tests_failed++;
      $display("FAIL lat_sample: got send=%b data=%h mask=%h, required 1 deadbeef 7", tx_send, tx_data, tx_mask);
    end
    repeat (4) begin
      @(negedge clk);
      if (tx_send !== 1'b1 || tx_data !== 32'hDEAD_BEEF || tx_mask !== 4'h7) unstable = 1'b1;
    end
    tests_run++;
    if (unstable) begin
      tests_failed++;
      $display("FAIL lat_hold: got send or data changed while waiting, required held");
    end
    tx_busy_man = 1'b1;
    @(negedge clk);
    tests_run++;
    if (tx_send !== 1'b0 || tx_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL lat_busy_ack: got send=%b data=%h, required 0 deadbeef", tx_send, tx_data);
    end
    tx_busy_man = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_done: got done=%b, required 1", done);
    end
    idle(5);
  endtask

  task automatic test_empty_mask();
    int t0, cycles;
    bit seen;
    tx_auto = 1'b1; busy_hold = 1;
    model_data = 32'hCAFE_0001; model_mask = 4'h0;
    t0 = n_send;
    pulse_start(20'd2);
    wait_done(100, cycles, seen);
    tests_run++;
    if (!seen || n_send - t0 != 2 || tx_mask !== 4'h0) begin
      tests_failed++;
      $display("FAIL empty_mask: got seen=%0d sends=%0d mask=%h, required 1 2 0", seen, n_send - t0, tx_mask);
    end
    idle(10);
  endtask

  task automatic test_long_busy();
    int s0, t0, sb0, ss0, cycles;
    bit seen;
    tx_auto = 1'b1; busy_hold = 100;
    model_data = 32'h0000_00A5; model_mask = 4'hF;
    s0 = n_strobe; t0 = n_send; sb0 = n_strobe_busy; ss0 = n_send_busy;
    pulse_start(20'd2);
    idle(20);
    pulse_start(20'd5);
    wait_done(400, cycles, seen);
    tests_run++;
    if (!seen || cycles != 190) begin
      tests_failed++;
      $display("FAIL long_done_time: got seen=%0d cycles=%0d, required 1 190", seen, cycles);
    end
    idle(3);
    tests_run++;
    if (n_strobe - s0 != 2 || n_send - t0 != 2) begin
      tests_failed++;
      $display("FAIL long_counts: got strobes=%0d sends=%0d, required 2 2", n_strobe - s0, n_send - t0);
    end
    tests_run++;
    if (n_strobe_busy != sb0 || n_send_busy != ss0) begin
      tests_failed++;
      $display("FAIL long_overlap: got strobe_in_busy=%0d send_in_busy=%0d, required 0 0",
               n_strobe_busy - sb0, n_send_busy - ss0);
    end
    busy_hold = 1;
    idle(5);
  endtask

  task automatic test_abort_wait();
    int s0, t0, d0;
    bit found;
    tx_auto = 1'b1; busy_hold = 1; model_mask = 4'hF;
    s0 = n_strobe; t0 = n_send; d0 = n_done;
    found = 1'b0;
    pulse_start(20'd5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_strobe === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL abort_wait_strobe2: got no second strobe in 50 cycles, required one");
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b1 || tx_send !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_wait_done: got done=%b send=%b, required 1 0", done, tx_send);
    end
    idle(30);
    tests_run++;
    if (n_strobe - s0 != 2 || n_send - t0 != 1 || n_done - d0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_wait_counts: got strobes=%0d sends=%0d dones=%0d busy=%b, required 2 1 1 0",
               n_strobe - s0, n_send - t0, n_done - d0, busy);
    end
  endtask

  task automatic test_abort_txwait();
    int s0;
    bit found, early;
    tx_auto = 1'b0; tx_busy_man = 1'b0;
    s0 = n_strobe; found = 1'b0; early = 1'b0;
    pulse_start(20'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL abort_tx_send: got no tx_send in 20 cycles, required one");
    end
    tx_busy_man = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL abort_tx_early: got done while tx_busy high, required done=0");
    end
    tx_busy_man = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_tx_done: got done=%b, required 1", done);
    end
    idle(20);
    tests_run++;
    if (n_strobe - s0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_tx_counts: got strobes=%0d busy=%b, required 1 0", n_strobe - s0, busy);
    end
    tx_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s0, d0;
    bit found;
    tx_auto = 1'b1; busy_hold = 1; found = 1'b0;
    pulse_start(20'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (!found || {rd_strobe, tx_send, busy, done} !== 4'b0 || {tx_data, tx_mask} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got found=%0d ctrl=%b data=%h mask=%h, required 1 0000 0 0",
               found, {rd_strobe, tx_send, busy, done}, tx_data, tx_mask);
    end
    rst_n = 1'b1;
    idle(8);
    s0 = n_strobe; d0 = n_done;
    pulse_start(20'hFFFFF);
    idle(300);
    tests_run++;
    if (n_strobe - s0 != 43 || busy !== 1'b1 || n_done != d0) begin
      tests_failed++;
      $display("FAIL big_count: got strobes=%0d busy=%b dones=%0d, required 43 1 0",
               n_strobe - s0, busy, n_done - d0);
    end
    idle(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL big_abort: got done=%b, required 1", done);
    end
    idle(10);
  endtask

  task automatic test_invariants();
    tests_run++;
    if (n_gap_viol != 0 || n_data_chg != 0 || n_send_busy != 0) begin
      tests_failed++;
      $display("FAIL invariants: got gap=%0d data_change=%0d send_in_busy=%0d, required 0 0 0",
               n_gap_viol, n_data_chg, n_send_busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; read_count = '0; abort = 1'b0;
    test_reset();
    test_basic();
    test_zero_count();
    test_latency();
    test_empty_mask();
    test_long_busy();
    test_abort_wait();
    test_abort_txwait();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
